// File: rtl/ps2_keycode_decoder_if.sv
// ps2_keycode_decoder_if: PS/2 pins and decoded key outputs of the keycode decoder
interface ps2_keycode_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode0;
  logic [7:0] keycode1;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;
  modport master (output ps2_clk, ps2_data, input keycode0, keycode1, scan_code, scan_valid, frame_err);
  modport slave (input ps2_clk, ps2_data, output keycode0, keycode1, scan_code, scan_valid, frame_err);
endinterface

// File: rtl/ps2_keycode_decoder.sv
// ps2_keycode_decoder: PS/2 set-2 frame receiver tracking two held keys as HID codes
module ps2_keycode_decoder #(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input logic clk_i,
  input logic rst_i,
  ps2_keycode_decoder_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t st_q;
  logic clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic [2:0] cnt_q;
  logic [TW-1:0] to_q;
  logic [7:0] sr_q, scan_q, kc0_q, kc1_q, kc0_d, kc1_d, hid;
  logic par_q, brk_q, ext_q, valid_q, err_q, fall, timeout;
  always_comb begin
    fall = clk_prev_q & ~clk_s2_q;
    timeout = st_q != IDLE && !fall && to_q == TW'(TIMEOUT_CYCLES);
    hid = ext_q ? (sr_q == 8'h6B ? 8'h50 : sr_q == 8'h74 ? 8'h4F : 8'h00)
                : (sr_q == 8'h1C ? 8'h04 : sr_q == 8'h23 ? 8'h07 : sr_q == 8'h1D ? 8'h1A :
                   sr_q == 8'h1B ? 8'h16 : sr_q == 8'h29 ? 8'h2C : sr_q == 8'h3B ? 8'h0D : 8'h00);
    kc0_d = kc0_q;
    kc1_d = kc1_q;
    if (hid != 8'h00 && !brk_q && hid != kc0_q && hid != kc1_q) begin
      kc0_d = kc0_q == 8'h00 ? hid : kc0_q;
      kc1_d = kc0_q != 8'h00 && kc1_q == 8'h00 ? hid : kc1_q;
    end else if (hid != 8'h00 && brk_q) begin
      // Releasing slot 0 pulls slot 1 down so the oldest held key stays first
      kc0_d = kc0_q == hid ? kc1_q : kc0_q;
      kc1_d = kc0_q == hid || kc1_q == hid ? 8'h00 : kc1_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q <= IDLE;
      {clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q} <= '1;
      cnt_q <= '0;
      to_q <= '0;
      sr_q <= '0;
      par_q <= 1'b0;
      scan_q <= '0;
      kc0_q <= '0;
      kc1_q <= '0;
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      {clk_s1_q, clk_s2_q, clk_prev_q} <= {bus.ps2_clk, clk_s1_q, clk_s2_q};
      {dat_s1_q, dat_s2_q} <= {bus.ps2_data, dat_s1_q};
      valid_q <= 1'b0;
      err_q <= 1'b0;
      to_q <= st_q == IDLE || fall ? '0 : to_q + TW'(1);
      if (timeout) begin
        st_q <= IDLE;
        err_q <= 1'b1;
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end else if (fall) begin
        case (st_q)
          IDLE: begin
            st_q <= dat_s2_q ? IDLE : DATA;
            cnt_q <= '0;
          end
          DATA: begin
            sr_q <= {dat_s2_q, sr_q[7:1]};
            cnt_q <= cnt_q + 3'd1;
            st_q <= cnt_q == 3'd7 ? PARITY : DATA;
          end
          PARITY: begin
            par_q <= dat_s2_q;
            st_q <= STOP;
          end
          default: begin
            st_q <= IDLE;
            if (dat_s2_q && ^{sr_q, par_q}) begin
              scan_q <= sr_q;
              valid_q <= 1'b1;
              if (sr_q == 8'hF0) brk_q <= 1'b1;
              else if (sr_q == 8'hE0) ext_q <= 1'b1;
              else begin
                kc0_q <= kc0_d;
                kc1_q <= kc1_d;
                brk_q <= 1'b0;
                ext_q <= 1'b0;
              end
            end else begin
              err_q <= 1'b1;
              brk_q <= 1'b0;
              ext_q <= 1'b0;
            end
          end
        endcase
      end
    end
  end
  assign bus.keycode0 = kc0_q;
  assign bus.keycode1 = kc1_q;
  assign bus.scan_code = scan_q;
  assign bus.scan_valid = valid_q;
  assign bus.frame_err = err_q;
endmodule
